// File: rtl/mips32_pkg.sv
// Shared MIPS32 front-end definitions: word width, NOP encoding, fetch FSM states
// and the address range helper used by the instruction memory.
package mips32_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } imem_state_e;

    // True when a byte address lies beyond a memory of 2**aw words.
    function automatic logic addr_oob(input logic [31:0] a, input int unsigned aw);
        return (a >> (aw + 2)) != 32'd0;
    endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch-stage <-> instruction memory bus: request, response and the word load port.
interface imem_responder_if;
    import mips32_pkg::*;

    logic              ice;
    logic [31:0]       iaddr;
    logic [WORD_W-1:0] inst;
    logic              inst_valid;
    logic              stall;
    logic              addr_err;
    logic              we;
    logic [31:0]       waddr;
    logic [WORD_W-1:0] wdata;

    modport master (
        output ice, iaddr, we, waddr, wdata,
        input  inst, inst_valid, stall, addr_err
    );

    modport slave (
        input  ice, iaddr, we, waddr, wdata,
        output inst, inst_valid, stall, addr_err
    );

endinterface

// File: rtl/imem_ram.sv
// Instruction word array: one write port, one registered read port.
// A read and write to the same word on one edge returns the old contents.
module imem_ram
    import mips32_pkg::*;
#(
    parameter int DEPTH = 1024,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    // Array is never reset so contents survive a mid-fetch reset.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_responder.sv
// Instruction memory responder: fixed-latency fetch FSM (IDLE/WAIT/RESP) over imem_ram.
// Define IMEM_ALIGN_CHECK_EN to also flag misaligned fetch addresses as addr_err.
module imem_responder
    import mips32_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    imem_responder_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    imem_state_e       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic              err_q, err_d;
    logic              accept, rd_en, wr_en, bad_d;
    logic [WORD_W-1:0] rdata;
    logic              valid_o, stall_o, aerr_o;

    assign accept = bus.ice && (state_q != ST_WAIT);
    assign addr_d = accept ? bus.iaddr : addr_q;
    // Every entry into RESP starts a new response, so the read fires on that edge.
    assign rd_en  = (state_d == ST_RESP);
    assign wr_en  = bus.we && !addr_oob(bus.waddr, AW);

`ifdef IMEM_ALIGN_CHECK_EN
    assign bad_d = addr_oob(addr_d, AW) || (addr_d[1:0] != 2'b00);
`else
    assign bad_d = addr_oob(addr_d, AW);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (bus.ice)                 state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
                else if (state_q == ST_RESP) state_d = ST_IDLE;
            end
            ST_WAIT: if (cnt_q == 4'd0) state_d = ST_RESP;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (accept)                                     cnt_d = CNT_INIT;
        else if (state_q == ST_WAIT && cnt_q != 4'd0)   cnt_d = cnt_q - 4'd1;
        err_d = rd_en ? bad_d : err_q;
    end

    always_comb begin
        valid_o = 1'b0;
        stall_o = 1'b0;
        aerr_o  = 1'b0;
        case (state_q)
            ST_WAIT: stall_o = 1'b1;
            ST_RESP: begin
                valid_o = 1'b1;
                aerr_o  = err_q;
            end
            default: ;
        endcase
    end

    imem_ram #(.DEPTH(DEPTH)) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (wr_en),
        .waddr_i (bus.waddr[AW+1:2]),
        .wdata_i (bus.wdata),
        .re_i    (rd_en),
        .raddr_i (addr_d[AW+1:2]),
        .rdata_o (rdata)
    );

    // A bad fetch returns NOP; inst holds between responses because err_q and rdata do.
    assign bus.inst       = err_q ? NOP : rdata;
    assign bus.inst_valid = valid_o;
    assign bus.stall      = stall_o;
    assign bus.addr_err   = aerr_o;

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, the instruction word count (power of two, 16..65536).
REQ-002 SHALL have parameter WAIT_CYCLES, default 0, the extra wait cycles per fetch (0..15).
REQ-003 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ice  input  1  fetch request valid from the fetch stage.
REQ-006 SHALL have port iaddr  input  32  byte address of the requested instruction.
REQ-007 SHALL have port inst  output  32  returned instruction word.
REQ-008 SHALL have port inst_valid  output  1  inst holds a completed fetch this cycle.
REQ-009 SHALL have port stall  output  1  request accepted but not yet answered; fetch must hold pc.
REQ-010 SHALL have port addr_err  output  1  the completed fetch was out of range or misaligned.
REQ-011 SHALL have ports we  input  1, waddr  input  32, wdata  input  32: byte-addressed word load port.

Function
REQ-012 SHALL implement FSM IDLE, WAIT, RESP, encoded per the shared package.
REQ-013 IDLE: on an edge with ice=1, SHALL latch iaddr; go to WAIT when WAIT_CYCLES>0 (counter loaded with WAIT_CYCLES-1), else RESP.
REQ-014 WAIT: stall=1; counter decrements each cycle; on counter==0 SHALL go to RESP.
REQ-015 RESP: inst_valid=1 for exactly one cycle; with ice=1 SHALL latch the new iaddr and re-enter WAIT/RESP per REQ-013 (back-to-back), else go to IDLE.
REQ-016 Latency SHALL be WAIT_CYCLES+1 cycles from the accepting edge to inst_valid; throughput one fetch per WAIT_CYCLES+1 cycles.
REQ-017 Word index SHALL be latched_addr[log2(DEPTH)+1:2]; latched_addr >= DEPTH*4 SHALL give inst=32'h00000000, addr_err=1.
REQ-018 inst SHALL be read from the array on the edge entering RESP and held stable until the next RESP.
REQ-019 Writes SHALL occur on any edge with we=1 regardless of FSM state; waddr[1:0] ignored; out-of-range waddr discarded.
REQ-020 A write on the same edge as the RESP read to the same word SHALL NOT be visible; old data is returned.
REQ-021 stall SHALL be 0 in IDLE and RESP; inst_valid and addr_err SHALL be 0 outside RESP.
REQ-022 ice=0 in WAIT SHALL NOT cancel the outstanding fetch.

Reset
REQ-023 rst_n low SHALL immediately force state IDLE, counter 0, inst 0, inst_valid 0, stall 0, addr_err 0.
REQ-024 Reset mid-fetch SHALL drop the request with no inst_valid; array contents SHALL be preserved.
REQ-025 First request SHALL be sampled on the first rising edge with rst_n high.

Configuration
REQ-026 With IMEM_ALIGN_CHECK_EN defined, latched_addr[1:0]!=0 SHALL give inst=32'h00000000, addr_err=1 at normal latency.
REQ-027 Without IMEM_ALIGN_CHECK_EN, iaddr[1:0] SHALL be ignored and addr_err SHALL flag out-of-range only.

Structure
REQ-028 FSM state typedef, NOP constant 32'h00000000 and word width SHALL live in shared package mips32_pkg.
REQ-029 The storage array SHALL be sub-module imem_ram (one write port, one registered read port); FSM and counter stay in imem_responder.

Verification
REQ-030 WAIT_CYCLES=0, word 4 preloaded 32'h24010005, ice=1 iaddr=0x10 -> inst_valid next cycle, inst=32'h24010005, stall never 1.
REQ-031 WAIT_CYCLES=3, ice=1 iaddr=0x0 -> stall=1 for 3 cycles, inst_valid on the 4th, back-to-back request 0x4 answered 4 cycles later.
REQ-032 DEPTH=1024, iaddr=0x1000 -> inst=0, addr_err=1; iaddr=0xFFC -> addr_err=0.
REQ-033 IMEM_ALIGN_CHECK_EN defined, iaddr=0x6 -> addr_err=1, inst=0; undefined -> returns word 1, addr_err=0.
REQ-034 WAIT_CYCLES=2, rst_n pulsed low in WAIT -> outputs 0 immediately, no inst_valid, preloaded data intact on the next fetch.
REQ-035 we=1 waddr=0x8 wdata=32'hAAAA5555 on the edge entering RESP for iaddr=0x8 -> old data returned; next fetch returns 32'hAAAA5555.
